// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared constants, Decode->Execute control bundle and the
//                bypass-select helper for the ARM pipeline controller.
//  Revision    : 1.0
// ============================================================================
package pipeline_pkg;

   localparam int ALU_CTRL_W = 3;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  alu_src;
      logic                  branch;
      logic                  pcs;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [1:0]            flag_write;
      logic [3:0]            cond;
      logic [3:0]            ra1;
      logic [3:0]            ra2;
      logic [3:0]            wa3;
   } de_ctrl_t;

   // The Memory-stage producer is younger, so it wins over Write-back.
   function automatic logic [1:0] fwd_select(
      input logic       rw_m,
      input logic [3:0] wa3_m,
      input logic       rw_w,
      input logic [3:0] wa3_w,
      input logic [3:0] ra
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (rw_m && (wa3_m == ra))
         sel = FWD_MEM;
      else if (rw_w && (wa3_w == ra))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_control_if
//  Description : Decoder/datapath bundle seen by the pipeline controller.
//  Revision    : 1.0
// ============================================================================
interface pipeline_control_if;
   import pipeline_pkg::*;

   logic                  RegWriteD;
   logic                  MemWriteD;
   logic                  MemtoRegD;
   logic                  ALUSrcD;
   logic                  BranchD;
   logic                  PCSD;
   logic [ALU_CTRL_W-1:0] ALUControlD;
   logic [1:0]            FlagWriteD;
   logic [3:0]            CondD;
   logic [3:0]            RA1D;
   logic [3:0]            RA2D;
   logic [3:0]            WA3D;
   logic [3:0]            ALUFlags;

   logic                  ALUSrcE;
   logic                  MemtoRegW;
   logic [ALU_CTRL_W-1:0] ALUControlE;
   logic                  MemWriteM;
   logic                  RegWriteW;
   logic [3:0]            WA3W;
   logic                  PCSrcW;
   logic                  BranchTakenE;
   logic [1:0]            ForwardAE;
   logic [1:0]            ForwardBE;
   logic                  StallF;
   logic                  StallD;
   logic                  FlushD;
   logic                  FlushE;
   logic [31:0]           StallCount;

   modport master (
      output RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD, PCSD,
             ALUControlD, FlagWriteD, CondD, RA1D, RA2D, WA3D, ALUFlags,
      input  ALUSrcE, MemtoRegW, ALUControlE, MemWriteM, RegWriteW, WA3W,
             PCSrcW, BranchTakenE, ForwardAE, ForwardBE, StallF, StallD,
             FlushD, FlushE, StallCount
   );

   modport slave (
      input  RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD, PCSD,
             ALUControlD, FlagWriteD, CondD, RA1D, RA2D, WA3D, ALUFlags,
      output ALUSrcE, MemtoRegW, ALUControlE, MemWriteM, RegWriteW, WA3W,
             PCSrcW, BranchTakenE, ForwardAE, ForwardBE, StallF, StallD,
             FlushD, FlushE, StallCount
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_control_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : ARM condition-code evaluation against NZCV; 1111 never fires.
//  Revision    : 1.0
// ============================================================================
module cond_check
   import pipeline_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic w_n, w_z, w_c, w_v, w_ge;

   assign w_n  = Flags[FLAG_N];
   assign w_z  = Flags[FLAG_Z];
   assign w_c  = Flags[FLAG_C];
   assign w_v  = Flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = w_z;
         COND_NE: CondEx = ~w_z;
         COND_CS: CondEx = w_c;
         COND_CC: CondEx = ~w_c;
         COND_MI: CondEx = w_n;
         COND_PL: CondEx = ~w_n;
         COND_VS: CondEx = w_v;
         COND_VC: CondEx = ~w_v;
         COND_HI: CondEx = w_c & ~w_z;
         COND_LS: CondEx = ~w_c | w_z;
         COND_GE: CondEx = w_ge;
         COND_LT: CondEx = ~w_ge;
         COND_GT: CondEx = ~w_z & w_ge;
         COND_LE: CondEx = w_z | ~w_ge;
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_control
//  Description : Five-stage ARM control pipeline with condition gating,
//                bypass selection, load-use / PC-write hazard handling.
//  Revision    : 1.0
// ============================================================================
module pipeline_control
   import pipeline_pkg::*;
#(
   parameter bit COND_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   pipeline_control_if.slave bus
);

   de_ctrl_t    w_ctrl_d;
   de_ctrl_t    r_ctrl_e;
   logic        w_cond_ex;
   logic [3:0]  r_flags;
   logic        r_reg_write_m, r_mem_write_m, r_mem_to_reg_m, r_pcs_m;
   logic [3:0]  r_wa3_m;
   logic        r_reg_write_w, r_mem_to_reg_w, r_pcs_w;
   logic [3:0]  r_wa3_w;
   logic [31:0] r_stall_count;
   logic        w_ldr_stall, w_pc_wr_pending, w_branch_taken_e, w_flush_e;

   assign w_ctrl_d = '{
      reg_write:  bus.RegWriteD,
      mem_write:  bus.MemWriteD,
      mem_to_reg: bus.MemtoRegD,
      alu_src:    bus.ALUSrcD,
      branch:     bus.BranchD,
      pcs:        bus.PCSD,
      alu_ctrl:   bus.ALUControlD,
      flag_write: bus.FlagWriteD,
      cond:       bus.CondD,
      ra1:        bus.RA1D,
      ra2:        bus.RA2D,
      wa3:        bus.WA3D
   };

   generate
      if (COND_EN) begin : g_cond_en
         cond_check u_cond_check (
            .Cond   (r_ctrl_e.cond),
            .Flags  (r_flags),
            .CondEx (w_cond_ex)
         );
      end else begin : g_cond_always
         assign w_cond_ex = 1'b1;
      end
   endgenerate

   // Hazard detection works purely on current stage state.
   assign w_branch_taken_e = r_ctrl_e.branch & w_cond_ex;
   assign w_ldr_stall      = r_ctrl_e.mem_to_reg & r_ctrl_e.reg_write &
                             ((bus.RA1D == r_ctrl_e.wa3) | (bus.RA2D == r_ctrl_e.wa3));
   assign w_pc_wr_pending  = bus.PCSD | r_ctrl_e.pcs | r_pcs_m;
   assign w_flush_e        = w_ldr_stall | w_branch_taken_e;

   // A flush squashes the stalled consumer rather than holding it in E.
   always_ff @(posedge clk) begin
      if (reset || w_flush_e)
         r_ctrl_e <= '0;
      else
         r_ctrl_e <= w_ctrl_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg_write_m  <= 1'b0;
         r_mem_write_m  <= 1'b0;
         r_mem_to_reg_m <= 1'b0;
         r_pcs_m        <= 1'b0;
         r_wa3_m        <= 4'd0;
         r_reg_write_w  <= 1'b0;
         r_mem_to_reg_w <= 1'b0;
         r_pcs_w        <= 1'b0;
         r_wa3_w        <= 4'd0;
      end else begin
         r_reg_write_m  <= r_ctrl_e.reg_write & w_cond_ex;
         r_mem_write_m  <= r_ctrl_e.mem_write & w_cond_ex;
         r_mem_to_reg_m <= r_ctrl_e.mem_to_reg;
         r_pcs_m        <= r_ctrl_e.pcs & w_cond_ex;
         r_wa3_m        <= r_ctrl_e.wa3;
         r_reg_write_w  <= r_reg_write_m;
         r_mem_to_reg_w <= r_mem_to_reg_m;
         r_pcs_w        <= r_pcs_m;
         r_wa3_w        <= r_wa3_m;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'd0;
      end else if (w_cond_ex) begin
         if (r_ctrl_e.flag_write[1])
            r_flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
         if (r_ctrl_e.flag_write[0])
            r_flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_stall_count <= 32'd0;
      else if (w_ldr_stall && (r_stall_count != 32'hFFFF_FFFF))
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign bus.ALUSrcE      = r_ctrl_e.alu_src;
   assign bus.ALUControlE  = r_ctrl_e.alu_ctrl;
   assign bus.MemWriteM    = r_mem_write_m;
   assign bus.MemtoRegW    = r_mem_to_reg_w;
   assign bus.RegWriteW    = r_reg_write_w;
   assign bus.WA3W         = r_wa3_w;
   assign bus.PCSrcW       = r_pcs_w;
   assign bus.BranchTakenE = w_branch_taken_e;
   assign bus.ForwardAE    = fwd_select(r_reg_write_m, r_wa3_m, r_reg_write_w, r_wa3_w, r_ctrl_e.ra1);
   assign bus.ForwardBE    = fwd_select(r_reg_write_m, r_wa3_m, r_reg_write_w, r_wa3_w, r_ctrl_e.ra2);
   assign bus.StallD       = w_ldr_stall;
   assign bus.StallF       = w_ldr_stall | w_pc_wr_pending;
   assign bus.FlushD       = w_pc_wr_pending | r_pcs_w | w_branch_taken_e;
   assign bus.FlushE       = w_flush_e;
   assign bus.StallCount   = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_control
//  Description : Directed scoreboard bench for the pipeline controller.
//  Revision    : 1.0
// ============================================================================
module tb_pipeline_control;
   import pipeline_pkg::*;

   localparam int S_FWDA = 0,  S_FWDB = 1,  S_STALLF = 2,  S_STALLD = 3,
                  S_FLUSHD = 4, S_FLUSHE = 5, S_BTE = 6,   S_REGWW = 7,
                  S_PCSRCW = 8, S_WA3W = 9,  S_MEMWM = 10, S_STALLCNT = 11,
                  S_ALUCE = 12, S_ALUSRCE = 13, S_MEMTOREGW = 14;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      int          scen;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   scen;
   int   n_vec;
   int   n_fail;
   bit   done;
   exp_t sb[$];

   pipeline_control_if bus ();

   pipeline_control #(.COND_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_FWDA:      return {30'd0, bus.ForwardAE};
         S_FWDB:      return {30'd0, bus.ForwardBE};
         S_STALLF:    return {31'd0, bus.StallF};
         S_STALLD:    return {31'd0, bus.StallD};
         S_FLUSHD:    return {31'd0, bus.FlushD};
         S_FLUSHE:    return {31'd0, bus.FlushE};
         S_BTE:       return {31'd0, bus.BranchTakenE};
         S_REGWW:     return {31'd0, bus.RegWriteW};
         S_PCSRCW:    return {31'd0, bus.PCSrcW};
         S_WA3W:      return {28'd0, bus.WA3W};
         S_MEMWM:     return {31'd0, bus.MemWriteM};
         S_STALLCNT:  return bus.StallCount;
         S_ALUCE:     return {29'd0, bus.ALUControlE};
         S_ALUSRCE:   return {31'd0, bus.ALUSrcE};
         S_MEMTOREGW: return {31'd0, bus.MemtoRegW};
         default:     return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_FWDA:      return "ForwardAE";
         S_FWDB:      return "ForwardBE";
         S_STALLF:    return "StallF";
         S_STALLD:    return "StallD";
         S_FLUSHD:    return "FlushD";
         S_FLUSHE:    return "FlushE";
         S_BTE:       return "BranchTakenE";
         S_REGWW:     return "RegWriteW";
         S_PCSRCW:    return "PCSrcW";
         S_WA3W:      return "WA3W";
         S_MEMWM:     return "MemWriteM";
         S_STALLCNT:  return "StallCount";
         S_ALUCE:     return "ALUControlE";
         S_ALUSRCE:   return "ALUSrcE";
         S_MEMTOREGW: return "MemtoRegW";
         default:     return "unknown";
      endcase
   endfunction

   // Monitor: compares every expectation that falls due in this cycle.
   always @(negedge clk) begin : monitor
      logic [31:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act = observe(sb[i].sel);
            n_vec++;
            if (act !== sb[i].val) begin
               n_fail++;
               $display("FAIL %s scen=%0d cyc=%0d got=%0h want=%0h",
                        sel_name(sb[i].sel), sb[i].scen, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc || done) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s scen=%0d never checked, got=none want=%0h",
                     sel_name(sb[i].sel), sb[i].scen, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dly, input int sel, input logic [31:0] val);
      exp_t e;
      e.cyc  = cyc + dly;
      e.sel  = sel;
      e.val  = val;
      e.scen = scen;
      sb.push_back(e);
   endtask

   task automatic expect_all_zero(input int dly);
      for (int s = S_FWDA; s <= S_MEMTOREGW; s++)
         expect_at(dly, s, 32'd0);
   endtask

   task automatic instr(input logic rw, input logic mw, input logic m2r,
                        input logic asrc, input logic br, input logic pcs,
                        input logic [2:0] aluc, input logic [1:0] fw,
                        input logic [3:0] cond, input logic [3:0] ra1,
                        input logic [3:0] ra2, input logic [3:0] wa3);
      bus.RegWriteD   = rw;
      bus.MemWriteD   = mw;
      bus.MemtoRegD   = m2r;
      bus.ALUSrcD     = asrc;
      bus.BranchD     = br;
      bus.PCSD        = pcs;
      bus.ALUControlD = aluc;
      bus.FlagWriteD  = fw;
      bus.CondD       = cond;
      bus.RA1D        = ra1;
      bus.RA2D        = ra2;
      bus.WA3D        = wa3;
   endtask

   task automatic nop();
      instr(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
   endtask

   task automatic drain(input int n);
      nop();
      bus.ALUFlags = 4'd0;
      repeat (n) tick();
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      done   = 1'b0;
      scen   = 0;
      reset  = 1'b1;
      bus.ALUFlags = 4'd0;
      nop();

      // Reset state
      tick();
      expect_all_zero(0);
      tick();
      reset = 1'b0;
      tick();

      // Load-use: one stall cycle then Write-back bypass
      scen = 1;
      instr(1, 0, 1, 1, 0, 0, 3'd0, 2'd0, COND_AL, 4'd1, 4'd0, 4'd2);
      expect_at(1, S_ALUSRCE, 1);
      expect_at(1, S_STALLF, 1);
      expect_at(1, S_STALLD, 1);
      expect_at(1, S_FLUSHE, 1);
      expect_at(1, S_FLUSHD, 0);
      expect_at(2, S_STALLD, 0);
      expect_at(2, S_FLUSHE, 0);
      expect_at(2, S_STALLCNT, 1);
      expect_at(3, S_FWDA, 1);
      expect_at(3, S_FWDB, 0);
      expect_at(3, S_ALUCE, 4);
      expect_at(3, S_REGWW, 1);
      expect_at(3, S_WA3W, 2);
      expect_at(3, S_MEMTOREGW, 1);
      expect_at(3, S_STALLCNT, 1);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd4, 2'd0, COND_AL, 4'd2, 4'd3, 4'd4);
      tick();
      tick();
      drain(4);

      // Back-to-back: Memory-stage bypass
      scen = 2;
      instr(1, 0, 0, 0, 0, 0, 3'd5, 2'd0, COND_AL, 4'd0, 4'd0, 4'd5);
      expect_at(1, S_ALUCE, 5);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd6, 4'd5, 4'd7);
      expect_at(0, S_STALLD, 0);
      expect_at(1, S_FWDB, 2);
      expect_at(1, S_FWDA, 0);
      tick();
      drain(4);

      // One gap: Write-back bypass
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd5);
      tick();
      nop();
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd6, 4'd5, 4'd7);
      expect_at(1, S_FWDB, 1);
      tick();
      drain(4);

      // Both stages match: Memory wins
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd5);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd5);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd5, 4'd5, 4'd7);
      expect_at(1, S_FWDA, 2);
      expect_at(1, S_FWDB, 2);
      tick();
      drain(4);

      // Address match without a register write: no bypass
      instr(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd5);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd5, 4'd0, 4'd7);
      expect_at(1, S_FWDA, 0);
      tick();
      drain(4);

      // Condition gating, flags start at zero
      scen = 3;
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_EQ, 4'd0, 4'd0, 4'd8);
      expect_at(3, S_REGWW, 0);
      expect_at(3, S_WA3W, 8);
      tick();
      drain(4);
      instr(0, 0, 0, 0, 0, 0, 3'd0, 2'b10, COND_AL, 4'd0, 4'd0, 4'd0);
      tick();
      bus.ALUFlags = 4'b0100;
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_EQ, 4'd0, 4'd0, 4'd9);
      expect_at(3, S_REGWW, 1);
      expect_at(3, S_WA3W, 9);
      tick();
      drain(4);
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 4'b1111, 4'd0, 4'd0, 4'd10);
      expect_at(3, S_REGWW, 0);
      tick();
      drain(4);
      instr(0, 1, 0, 0, 0, 0, 3'd0, 2'd0, COND_NE, 4'd0, 4'd0, 4'd0);
      expect_at(2, S_MEMWM, 0);
      tick();
      instr(0, 1, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd0);
      expect_at(2, S_MEMWM, 1);
      tick();
      drain(4);

      // Field-wise flag update: only C,V written (N=0 Z=1 C=1 V=1 after)
      instr(0, 0, 0, 0, 0, 0, 3'd0, 2'b01, COND_AL, 4'd0, 4'd0, 4'd0);
      tick();
      bus.ALUFlags = 4'b1111;
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_MI, 4'd0, 4'd0, 4'd11);
      expect_at(3, S_REGWW, 0);
      tick();
      bus.ALUFlags = 4'b0000;
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_CS, 4'd0, 4'd0, 4'd12);
      expect_at(3, S_REGWW, 1);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_GT, 4'd0, 4'd0, 4'd13);
      expect_at(3, S_REGWW, 0);
      tick();
      drain(4);

      // Failed condition must not write flags
      instr(0, 0, 0, 0, 0, 0, 3'd0, 2'b11, COND_NE, 4'd0, 4'd0, 4'd0);
      tick();
      bus.ALUFlags = 4'b0000;
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_EQ, 4'd0, 4'd0, 4'd14);
      expect_at(3, S_REGWW, 1);
      tick();
      drain(4);

      // Taken branch flushes D and E for one cycle
      scen = 4;
      instr(0, 0, 0, 0, 1, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd0);
      expect_at(0, S_BTE, 0);
      expect_at(1, S_BTE, 1);
      expect_at(1, S_FLUSHD, 1);
      expect_at(1, S_FLUSHE, 1);
      expect_at(1, S_STALLD, 0);
      expect_at(2, S_BTE, 0);
      expect_at(2, S_FLUSHD, 0);
      expect_at(2, S_FLUSHE, 0);
      expect_at(4, S_REGWW, 0);
      expect_at(4, S_WA3W, 0);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd6);
      tick();
      drain(4);
      instr(0, 0, 0, 0, 1, 0, 3'd0, 2'd0, COND_NE, 4'd0, 4'd0, 4'd0);
      expect_at(1, S_BTE, 0);
      expect_at(1, S_FLUSHD, 0);
      tick();
      drain(4);

      // Load-use coinciding with a taken branch: consumer squashed
      scen = 5;
      instr(1, 0, 1, 0, 1, 0, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd3);
      tick();
      instr(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, COND_AL, 4'd3, 4'd0, 4'd10);
      expect_at(0, S_FLUSHE, 1);
      expect_at(0, S_FLUSHD, 1);
      expect_at(0, S_BTE, 1);
      expect_at(0, S_STALLD, 1);
      expect_at(1, S_STALLCNT, 2);
      expect_at(2, S_REGWW, 1);
      expect_at(2, S_WA3W, 3);
      expect_at(3, S_REGWW, 0);
      expect_at(3, S_WA3W, 0);
      tick();
      drain(5);

      // PC write travelling to Write-back
      scen = 6;
      instr(1, 0, 0, 0, 0, 1, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd15);
      expect_at(0, S_STALLF, 1);
      expect_at(0, S_FLUSHD, 1);
      expect_at(0, S_STALLD, 0);
      expect_at(1, S_STALLF, 1);
      expect_at(1, S_FLUSHD, 1);
      expect_at(2, S_STALLF, 1);
      expect_at(2, S_FLUSHD, 1);
      expect_at(3, S_PCSRCW, 1);
      expect_at(3, S_FLUSHD, 1);
      expect_at(3, S_STALLF, 0);
      expect_at(4, S_PCSRCW, 0);
      expect_at(4, S_FLUSHD, 0);
      tick();
      drain(5);
      instr(1, 0, 0, 0, 0, 1, 3'd0, 2'd0, COND_NE, 4'd0, 4'd0, 4'd15);
      expect_at(1, S_FLUSHD, 1);
      expect_at(2, S_FLUSHD, 0);
      expect_at(2, S_STALLF, 0);
      expect_at(3, S_PCSRCW, 0);
      tick();
      drain(5);

      // Reset while the PC write sits in Memory
      scen = 7;
      instr(1, 0, 0, 0, 0, 1, 3'd0, 2'd0, COND_AL, 4'd0, 4'd0, 4'd15);
      tick();
      nop();
      tick();
      reset = 1'b1;
      expect_at(0, S_STALLF, 1);
      expect_all_zero(1);
      expect_at(2, S_PCSRCW, 0);
      expect_at(2, S_REGWW, 0);
      expect_at(3, S_PCSRCW, 0);
      tick();
      reset = 1'b0;
      tick();
      drain(4);

      done = 1'b1;
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
